// File: rtl/trireg_bus_keeper_if.sv
`default_nettype none
// ============================================================================
// Module      : trireg_bus_keeper_if
// Description : Select/data inputs and retained-net status outputs of the
//               trireg bus keeper.
// Revision    : 1.0  initial release
// ============================================================================
interface trireg_bus_keeper_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       sel;
    logic [WIDTH-1:0] drv_data;
    logic [WIDTH-1:0] bus_data;
    logic             bus_driven;
    logic             bus_valid;
    logic             charge_lost;
    logic [7:0]       hold_entries;

    modport master (
        output sel,
        output drv_data,
        input  bus_data,
        input  bus_driven,
        input  bus_valid,
        input  charge_lost,
        input  hold_entries
    );

    modport slave (
        input  sel,
        input  drv_data,
        output bus_data,
        output bus_driven,
        output bus_valid,
        output charge_lost,
        output hold_entries
    );
endinterface
`default_nettype wire

// File: rtl/trireg_bus_keeper.sv
`default_nettype none
// ============================================================================
// Module      : trireg_bus_keeper
// Description : Charge-storage net model. Holds the last driven value after
//               release and decays it to FLOAT_VALUE after DECAY_CYCLES.
// Revision    : 1.0  initial release
// ============================================================================
module trireg_bus_keeper #(
    parameter int WIDTH        = 8,
    parameter int DECAY_CYCLES = 16,
    parameter int CONST_2      = 255,
    parameter int CONST_3      = 30,
    parameter int FLOAT_VALUE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    trireg_bus_keeper_if.slave bus
);

    localparam int                 c_AGE_W     = $clog2(DECAY_CYCLES) + 1;
    localparam logic [c_AGE_W-1:0] c_AGE_LAST  = (DECAY_CYCLES == 0) ? '0 : c_AGE_W'(DECAY_CYCLES - 1);
    localparam logic [c_AGE_W-1:0] c_AGE_ONE   = c_AGE_W'(1);
    localparam logic [WIDTH-1:0]   c_CONST_2   = WIDTH'(CONST_2);
    localparam logic [WIDTH-1:0]   c_CONST_3   = WIDTH'(CONST_3);
    localparam logic [WIDTH-1:0]   c_FLOAT     = WIDTH'(FLOAT_VALUE);
    localparam logic [7:0]         c_HOLD_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_DRIVEN = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_bus_data;
    logic [WIDTH-1:0]   w_bus_data_nxt;
    logic [WIDTH-1:0]   w_src;
    logic [c_AGE_W-1:0] r_age;
    logic [c_AGE_W-1:0] w_age_nxt;
    logic [7:0]         r_hold_entries;
    logic [7:0]         w_hold_entries_nxt;
    logic               r_charge_lost;
    logic               w_charge_lost_nxt;
    logic               r_bus_driven;
    logic               r_bus_valid;
    logic               w_decay_on;
    logic               w_decay_hit;

    // With DECAY_CYCLES==0 the charge is kept forever and age stays frozen.
    generate
        if (DECAY_CYCLES == 0) begin : g_no_decay
            assign w_decay_on  = 1'b0;
            assign w_decay_hit = 1'b0;
        end else begin : g_decay
            assign w_decay_on  = 1'b1;
            assign w_decay_hit = (r_age == c_AGE_LAST);
        end
    endgenerate

    always_comb begin
        w_src = c_CONST_3;
        case (bus.sel)
            2'd1:    w_src = bus.drv_data;
            2'd2:    w_src = c_CONST_2;
            default: w_src = c_CONST_3;
        endcase
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_bus_data_nxt     = r_bus_data;
        w_age_nxt          = r_age;
        w_hold_entries_nxt = r_hold_entries;
        w_charge_lost_nxt  = 1'b0;

        // Any active driver wins, including on the decay edge.
        if (bus.sel != 2'd0) begin
            w_state_nxt    = S_DRIVEN;
            w_bus_data_nxt = w_src;
            w_age_nxt      = '0;
        end else begin
            case (r_state)
                S_DRIVEN: begin
                    w_state_nxt = S_HOLD;
                    w_age_nxt   = '0;
                    if (r_hold_entries != c_HOLD_MAX) begin
                        w_hold_entries_nxt = r_hold_entries + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (w_decay_on) begin
                        if (w_decay_hit) begin
                            w_state_nxt       = S_EMPTY;
                            w_bus_data_nxt    = c_FLOAT;
                            w_age_nxt         = '0;
                            w_charge_lost_nxt = 1'b1;
                        end else begin
                            w_age_nxt = r_age + c_AGE_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt    = S_EMPTY;
                    w_bus_data_nxt = c_FLOAT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_EMPTY;
            r_bus_data     <= c_FLOAT;
            r_age          <= '0;
            r_hold_entries <= '0;
            r_charge_lost  <= 1'b0;
            r_bus_driven   <= 1'b0;
            r_bus_valid    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_bus_data     <= w_bus_data_nxt;
            r_age          <= w_age_nxt;
            r_hold_entries <= w_hold_entries_nxt;
            r_charge_lost  <= w_charge_lost_nxt;
            r_bus_driven   <= (w_state_nxt == S_DRIVEN);
            r_bus_valid    <= (w_state_nxt != S_EMPTY);
        end
    end

    assign bus.bus_data     = r_bus_data;
    assign bus.bus_driven   = r_bus_driven;
    assign bus.bus_valid    = r_bus_valid;
    assign bus.charge_lost  = r_charge_lost;
    assign bus.hold_entries = r_hold_entries;

endmodule
`default_nettype wire

// File: tb/tb_trireg_bus_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_trireg_bus_keeper
// Description : Scoreboard bench for trireg_bus_keeper, decaying and
//               non-decaying builds driven with identical stimulus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_trireg_bus_keeper;

    typedef struct {
        int         st;     // 0 empty, 1 driven, 2 hold
        logic [7:0] data;
        int         age;
        int         hold;
        logic       lost;
    } mdl_t;

    typedef struct {
        logic [7:0] data;
        logic       driven;
        logic       valid;
        logic       lost;
        logic [7:0] hold;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    mdl_t m_a = '{0, 8'd0, 0, 0, 1'b0};
    mdl_t m_b = '{0, 8'd0, 0, 0, 1'b0};
    exp_t q_a[$];
    exp_t q_b[$];

    trireg_bus_keeper_if #(.WIDTH(8)) if_a ();
    trireg_bus_keeper_if #(.WIDTH(8)) if_b ();

    trireg_bus_keeper #(
        .WIDTH(8), .DECAY_CYCLES(16), .CONST_2(255), .CONST_3(30), .FLOAT_VALUE(0)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(if_a)
    );

    trireg_bus_keeper #(
        .WIDTH(8), .DECAY_CYCLES(0), .CONST_2(255), .CONST_3(30), .FLOAT_VALUE(0)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(if_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within 1ms");
        $fatal(1, "timeout");
    end

    function automatic mdl_t mdl_next(mdl_t m, logic r, logic [1:0] s, logic [7:0] d, int decay);
        mdl_t n = m;
        n.lost = 1'b0;
        if (r) begin
            n.st = 0; n.data = 8'd0; n.age = 0; n.hold = 0;
        end else if (s != 2'd0) begin
            n.st   = 1;
            n.age  = 0;
            n.data = (s == 2'd1) ? d : ((s == 2'd2) ? 8'd255 : 8'd30);
        end else if (m.st == 1) begin
            n.st  = 2;
            n.age = 0;
            if (m.hold < 255) n.hold = m.hold + 1;
        end else if (m.st == 2 && decay != 0) begin
            if (m.age == decay - 1) begin
                n.st = 0; n.data = 8'd0; n.age = 0; n.lost = 1'b1;
            end else begin
                n.age = m.age + 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mdl_t m);
        exp_t e;
        e.data   = m.data;
        e.driven = (m.st == 1);
        e.valid  = (m.st != 0);
        e.lost   = m.lost;
        e.hold   = 8'(m.hold);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic score(input string name, inout exp_t q[$], input logic [7:0] data,
                         input logic driven, input logic valid, input logic lost,
                         input logic [7:0] hold);
        exp_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_queue observed=empty expected=entry", name);
        end else begin
            e = q.pop_front();
            chk({name, "_data"},   32'(data),   32'(e.data));
            chk({name, "_driven"}, 32'(driven), 32'(e.driven));
            chk({name, "_valid"},  32'(valid),  32'(e.valid));
            chk({name, "_lost"},   32'(lost),   32'(e.lost));
            chk({name, "_hold"},   32'(hold),   32'(e.hold));
        end
    endtask

    task automatic step(input logic r, input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        rst           = r;
        if_a.sel      = s;
        if_a.drv_data = d;
        if_b.sel      = s;
        if_b.drv_data = d;
        m_a = mdl_next(m_a, r, s, d, 16);
        m_b = mdl_next(m_b, r, s, d, 0);
        q_a.push_back(to_exp(m_a));
        q_b.push_back(to_exp(m_b));
        @(posedge clk);
        #1;
        score("a", q_a, if_a.bus_data, if_a.bus_driven, if_a.bus_valid, if_a.charge_lost, if_a.hold_entries);
        score("b", q_b, if_b.bus_data, if_b.bus_driven, if_b.bus_valid, if_b.charge_lost, if_b.hold_entries);
    endtask

    initial begin
        if_a.sel = 2'd0; if_a.drv_data = 8'd0;
        if_b.sel = 2'd0; if_b.drv_data = 8'd0;

        // Single drive, full decay window
        step(1'b1, 2'd0, 8'd0);
        chk("rst_data",  32'(if_a.bus_data),     32'd0);
        chk("rst_valid", 32'(if_a.bus_valid),    32'd0);
        chk("rst_drv",   32'(if_a.bus_driven),   32'd0);
        chk("rst_hold",  32'(if_a.hold_entries), 32'd0);
        step(1'b0, 2'd1, 8'd10);
        chk("t1_drive_data", 32'(if_a.bus_data),   32'd10);
        chk("t1_drive_drv",  32'(if_a.bus_driven), 32'd1);
        repeat (16) step(1'b0, 2'd0, 8'd0);
        chk("t1_hold_valid", 32'(if_a.bus_valid),   32'd1);
        chk("t1_hold_data",  32'(if_a.bus_data),    32'd10);
        chk("t1_hold_lost",  32'(if_a.charge_lost), 32'd0);
        step(1'b0, 2'd0, 8'd0);
        chk("t1_decay_lost",  32'(if_a.charge_lost), 32'd1);
        chk("t1_decay_data",  32'(if_a.bus_data),    32'd0);
        chk("t1_decay_valid", 32'(if_a.bus_valid),   32'd0);
        chk("t1_b_keeps",     32'(if_b.bus_data),    32'd10);
        step(1'b0, 2'd0, 8'd0);
        chk("t1_pulse_end", 32'(if_a.charge_lost), 32'd0);

        // Re-drive during hold restarts the window
        step(1'b1, 2'd0, 8'd0);
        step(1'b0, 2'd3, 8'd0);
        repeat (5) step(1'b0, 2'd0, 8'd0);
        chk("t2_hold30", 32'(if_a.bus_data), 32'd30);
        step(1'b0, 2'd2, 8'd0);
        repeat (16) step(1'b0, 2'd0, 8'd0);
        chk("t2_hold255", 32'(if_a.bus_data),     32'd255);
        chk("t2_entries", 32'(if_a.hold_entries), 32'd2);
        chk("t2_nolost",  32'(if_a.charge_lost),  32'd0);
        step(1'b0, 2'd0, 8'd0);
        chk("t2_lost", 32'(if_a.charge_lost), 32'd1);

        // Idle from reset
        step(1'b1, 2'd0, 8'd0);
        repeat (20) step(1'b0, 2'd0, 8'd0);
        chk("t3_valid", 32'(if_a.bus_valid),    32'd0);
        chk("t3_hold",  32'(if_a.hold_entries), 32'd0);

        // Non-decaying build keeps charge indefinitely
        step(1'b1, 2'd0, 8'd0);
        step(1'b0, 2'd1, 8'hA5);
        repeat (1000) step(1'b0, 2'd0, 8'd0);
        chk("t4_data",  32'(if_b.bus_data),    32'hA5);
        chk("t4_valid", 32'(if_b.bus_valid),   32'd1);
        chk("t4_lost",  32'(if_b.charge_lost), 32'd0);

        // Reset in the middle of a hold window
        step(1'b1, 2'd0, 8'd0);
        step(1'b0, 2'd1, 8'h3C);
        repeat (7) step(1'b0, 2'd0, 8'd0);
        step(1'b1, 2'd0, 8'd0);
        chk("t5_data",  32'(if_a.bus_data),     32'd0);
        chk("t5_valid", 32'(if_a.bus_valid),    32'd0);
        chk("t5_lost",  32'(if_a.charge_lost),  32'd0);
        chk("t5_hold",  32'(if_a.hold_entries), 32'd0);
        repeat (20) step(1'b0, 2'd0, 8'd0);

        // Hold counter saturation and drive on the decay edge
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 2'd1, 8'(i));
            step(1'b0, 2'd0, 8'd0);
        end
        chk("t6_sat_a", 32'(if_a.hold_entries), 32'd255);
        chk("t6_sat_b", 32'(if_b.hold_entries), 32'd255);
        step(1'b0, 2'd1, 8'h77);
        repeat (16) step(1'b0, 2'd0, 8'd0);
        step(1'b0, 2'd2, 8'd0);
        chk("t6_edge_data", 32'(if_a.bus_data),    32'd255);
        chk("t6_edge_lost", 32'(if_a.charge_lost), 32'd0);
        chk("t6_edge_drv",  32'(if_a.bus_driven),  32'd1);
        step(1'b0, 2'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
